// File: rtl/life_grid_engine.sv
// life_grid_engine: Game-of-Life grid with row-serial loading and N-generation runs; LIFE_STABLE_DETECT_EN adds `stable` and stops early on a still life.
module life_grid_engine #(
  parameter int WIDTH = 17,
  parameter int HEIGHT = 17,
  parameter int WRAP = 1,
  parameter logic [8:0] BIRTH_MASK = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter int GEN_W = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load_valid,
  output logic load_ready,
  input  logic [WIDTH-1:0] load_row,
  input  logic run_valid,
  output logic run_ready,
  input  logic [GEN_W-1:0] run_gens,
  output logic busy,
  output logic done,
  output logic [GEN_W-1:0] gen_count,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] population,
`ifdef LIFE_STABLE_DETECT_EN
  output logic stable,
`endif
  output logic [WIDTH*HEIGHT-1:0] states
);
  localparam int N = WIDTH * HEIGHT;
  localparam int PW = $clog2(N + 1);
  localparam int PTW = $clog2(HEIGHT);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, nstate;
  logic [PTW-1:0] ptr;
  logic [GEN_W-1:0] remaining;
  logic [N-1:0] nxt;
  logic hold, load_acc, run_acc;

  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      localparam int RU = (r + HEIGHT - 1) % HEIGHT;
      localparam int RD = (r + 1) % HEIGHT;
      localparam int CL = (c + WIDTH - 1) % WIDTH;
      localparam int CR = (c + 1) % WIDTH;
      localparam bit U = (WRAP != 0) || (r > 0);
      localparam bit D = (WRAP != 0) || (r < HEIGHT - 1);
      localparam bit L = (WRAP != 0) || (c > 0);
      localparam bit R = (WRAP != 0) || (c < WIDTH - 1);
      logic [7:0] nb;
      logic [3:0] cnt;
      assign nb = {U && L && states[RU*WIDTH+CL], U && states[RU*WIDTH+c], U && R && states[RU*WIDTH+CR],
                   L && states[r*WIDTH+CL], R && states[r*WIDTH+CR],
                   D && L && states[RD*WIDTH+CL], D && states[RD*WIDTH+c], D && R && states[RD*WIDTH+CR]};
      assign cnt = 4'($countones(nb));
      assign nxt[r*WIDTH+c] = states[r*WIDTH+c] ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
    end
  end

`ifdef LIFE_STABLE_DETECT_EN
  assign hold = (nxt == states);
`else
  assign hold = 1'b0;
`endif

  assign population = PW'($countones(states));
  assign busy = (state == LOAD) || (state == RUN);
  assign done = (state == DONE);
  assign load_acc = load_valid && load_ready;
  assign run_acc = run_valid && run_ready;

  // Next-state and handshake readies; load wins over run when both arrive in IDLE
  always_comb begin
    nstate = state;
    load_ready = 1'b0;
    run_ready = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        run_ready = !load_valid;
        if (load_valid) nstate = LOAD;
        else if (run_valid) nstate = (run_gens == '0) ? DONE : RUN;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid && ptr == PTW'(HEIGHT - 1)) nstate = IDLE;
      end
      RUN: nstate = (hold || remaining == GEN_W'(1)) ? DONE : RUN;
      default: nstate = IDLE;
    endcase
  end

  // State, row pointer, grid and generation bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      remaining <= '0;
      gen_count <= '0;
      states <= '0;
    end else begin
      state <= nstate;
      if (load_acc) begin
        for (int i = 0; i < HEIGHT; i++) if (ptr == PTW'(i)) states[i*WIDTH +: WIDTH] <= load_row;
        ptr <= (ptr == PTW'(HEIGHT - 1)) ? '0 : ptr + 1'b1;
        if (state == IDLE) gen_count <= '0;
      end
      if (run_acc) remaining <= run_gens;
      if (state == RUN && !hold) begin
        states <= nxt;
        remaining <= remaining - 1'b1;
        if (!(&gen_count)) gen_count <= gen_count + 1'b1;
      end
    end
  end

`ifdef LIFE_STABLE_DETECT_EN
  // Flag a run that ended because the grid stopped changing; cleared by the next command
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stable <= 1'b0;
    else if (load_acc || run_acc) stable <= 1'b0;
    else if (state == RUN && hold) stable <= 1'b1;
  end
`endif
endmodule
